// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, horizontal/vertical counters,
// registered sync/video/coordinate outputs and a frame-synchronous test pattern
// (solid, colour bars, checker, black) selected by shadowed inputs.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int PIX_DIV  = 2,
    parameter int RGB_W    = 1,
    parameter int CHK_LOG2 = 5,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         rgbswitches,
    input  logic [1:0]         mode,
    output logic [3*RGB_W-1:0] rgbtext,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [XW-1:0]      pixel_x,
    output logic [YW-1:0]      pixel_y,
    output logic               frame_start
);

    localparam int DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int BAR_W = H_ACTIVE / 8;

    logic [DW-1:0] div_q;
    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic [1:0]    mode_sh;
    logic [2:0]    rgb_sh;
    logic          fs_pend;

    logic          tick;
    logic          h_end;
    logic          v_end;
    logic          frame_end;

    assign tick      = (div_q == DW'(PIX_DIV - 1));
    assign h_end     = (h_cnt == XW'(H_TOTAL - 1));
    assign v_end     = (v_cnt == YW'(V_TOTAL - 1));
    // Last tick of the last pixel of the frame: counters wrap to (0,0) here.
    assign frame_end = tick & h_end & v_end;

    // Pixel-tick divider: counts 0..PIX_DIV-1 and wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Horizontal and vertical position counters, advanced on pixel ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_end) begin
                h_cnt <= '0;
                v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Shadow pattern controls so changes only land on frame boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_sh <= 2'b00;
            rgb_sh  <= 3'b000;
            fs_pend <= 1'b0;
        end else begin
            // fs_pend lines the pulse up with the registered outputs for (0,0);
            // it is only set by a wrap, so the first frame after reset is silent.
            fs_pend <= frame_end;
            if (frame_end) begin
                mode_sh <= mode;
                rgb_sh  <= rgbswitches;
            end
        end
    end

    logic       active;
    logic       hs_on;
    logic       vs_on;
    logic [2:0] bar;
    logic       chk;
    logic [2:0] colour;
    logic [3*RGB_W-1:0] rgb_d;

    // Decode counters into region flags and the pattern colour.
    always_comb begin
        active = (h_cnt < XW'(H_ACTIVE)) && (v_cnt < YW'(V_ACTIVE));
        hs_on  = (h_cnt >= XW'(H_ACTIVE + H_FP)) && (h_cnt <= XW'(H_ACTIVE + H_FP + H_SYNC - 1));
        vs_on  = (v_cnt >= YW'(V_ACTIVE + V_FP)) && (v_cnt <= YW'(V_ACTIVE + V_FP + V_SYNC - 1));
        bar    = 3'(h_cnt / XW'(BAR_W));
        chk    = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];
        colour = 3'b000;
        if (active) begin
            case (mode_sh)
                2'd0:    colour = rgb_sh;
                2'd1:    colour = 3'd7 - bar;
                2'd2:    colour = chk ? ~rgb_sh : rgb_sh;
                default: colour = 3'b000;
            endcase
        end
        rgb_d = {{RGB_W{colour[2]}}, {RGB_W{colour[1]}}, {RGB_W{colour[0]}}};
    end

    // Output registers: one clk behind the counters, all mutually aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            rgbtext     <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_on ? H_POL : ~H_POL;
            vsync       <= vs_on ? V_POL : ~V_POL;
            video_on    <= active;
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            rgbtext     <= rgb_d;
            frame_start <= fs_pend;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two instances (divided 1-bit colour, undivided 4-bit
// colour with active-high syncs) on a reduced raster, checked every clk against
// an elapsed-time model plus explicit timing and pattern points.
module tb_vga_sync_gen;

    localparam int HA = 48, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 36, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FR = HT * VT;
    localparam int PDA = 2, PDB = 1, CHK = 32;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        von;
        logic [5:0]  px;
        logic [5:0]  py;
        logic [11:0] rgb;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] sw = 3'b000;
    logic [1:0] mode = 2'b00;

    logic [2:0]  rgb_a;
    logic        hs_a, vs_a, von_a, fs_a;
    logic [5:0]  px_a, py_a;
    logic [11:0] rgb_b;
    logic        hs_b, vs_b, von_b, fs_b;
    logic [5:0]  px_b, py_b;

    exp_t obs_a, obs_b, exp_a, exp_b;
    assign obs_a = {hs_a, vs_a, von_a, px_a, py_a, 9'd0, rgb_a, fs_a};
    assign obs_b = {hs_b, vs_b, von_b, px_b, py_b, rgb_b, fs_b};

    int n = 0;
    int checks = 0;
    int failures = 0;
    logic [1:0] sh_mode_a = 2'b00, sh_mode_b = 2'b00;
    logic [2:0] sh_sw_a = 3'b000, sh_sw_b = 3'b000;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(PDA), .RGB_W(1), .CHK_LOG2(5)
    ) dut_a (
        .clk(clk), .reset(reset), .rgbswitches(sw), .mode(mode),
        .rgbtext(rgb_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
        .pixel_x(px_a), .pixel_y(py_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(PDB), .RGB_W(4), .CHK_LOG2(5)
    ) dut_b (
        .clk(clk), .reset(reset), .rgbswitches(sw), .mode(mode),
        .rgbtext(rgb_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
        .pixel_x(px_b), .pixel_y(py_b), .frame_start(fs_b)
    );

    always #5 clk = ~clk;

    // Expected outputs after nn clk edges since reset release.
    function automatic exp_t model(input int nn, input int pd, input int rgbw, input bit pol,
                                   input logic [1:0] md, input logic [2:0] c_sw);
        exp_t e;
        int cnt, h, v;
        logic [2:0] c;
        e = '0;
        e.hs = ~pol;
        e.vs = ~pol;
        if (nn == 0) return e;
        cnt = (nn - 1) / pd;
        h = cnt % HT;
        v = (cnt / HT) % VT;
        e.px = 6'(h);
        e.py = 6'(v);
        e.von = (h < HA) && (v < VA);
        if (h >= HA + HFP && h < HA + HFP + HS) e.hs = pol;
        if (v >= VA + VFP && v < VA + VFP + VS) e.vs = pol;
        e.fs = (cnt > 0) && (cnt % FR == 0) && ((nn - 1) % pd == 0);
        c = 3'b000;
        if (e.von) begin
            case (md)
                2'd0:    c = c_sw;
                2'd1:    c = 3'(7 - h / (HA / 8));
                2'd2:    c = ((h / CHK + v / CHK) % 2 == 0) ? c_sw : ~c_sw;
                default: c = 3'b000;
            endcase
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < rgbw; j++) e.rgb[i * rgbw + j] = c[i];
        return e;
    endfunction

    // One clk edge: update the model, then return at the following falling edge.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            n++;
            exp_a = model(n, PDA, 1, 1'b0, sh_mode_a, sh_sw_a);
            exp_b = model(n, PDB, 4, 1'b1, sh_mode_b, sh_sw_b);
            if (n % PDA == 0 && (n / PDA) % FR == 0) begin
                sh_mode_a = mode;
                sh_sw_a = sw;
            end
            if (n % PDB == 0 && (n / PDB) % FR == 0) begin
                sh_mode_b = mode;
                sh_sw_b = sw;
            end
        end else begin
            n = 0;
            sh_mode_a = 2'b00; sh_sw_a = 3'b000;
            sh_mode_b = 2'b00; sh_sw_b = 3'b000;
            exp_a = model(0, PDA, 1, 1'b0, 2'b00, 3'b000);
            exp_b = model(0, PDB, 4, 1'b1, 2'b00, 3'b000);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first_move;
        #1 reset = 1'b0;
        #1;
        exp_a = model(0, PDA, 1, 1'b0, 2'b00, 3'b000);
        exp_b = model(0, PDB, 4, 1'b1, 2'b00, 3'b000);
        checks++;
        if (obs_a !== exp_a) begin
            failures++;
            $display("FAIL reset_async_a got=%h exp=%h", obs_a, exp_a);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            advance();
            checks += 2;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL reset_hold_a got=%h exp=%h", obs_a, exp_a);
            end
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL reset_hold_b got=%h exp=%h", obs_b, exp_b);
            end
        end
        reset = 1'b1;
        first_move = -1;
        for (int k = 0; k < 20; k++) begin
            advance();
            checks += 2;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL reset_release_a n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL reset_release_b n=%0d got=%h exp=%h", n, obs_b, exp_b);
            end
            if (first_move < 0 && px_a == 6'd1) first_move = n;
        end
        checks++;
        if (first_move != PDA + 1) begin
            failures++;
            $display("FAIL first_tick_latency got=%0d exp=%0d", first_move, PDA + 1);
        end
    endtask

    task automatic test_sync_timing();
        logic p_hs_a, p_vs_a, p_hs_b;
        int a_fall = -1, a_vfall = -1, b_rise = -1, fs_last = -1, fs_seen = 0;
        bit d_line = 0, d_hw = 0, d_vw = 0, d_bline = 0, d_bw = 0;
        p_hs_a = hs_a; p_vs_a = vs_a; p_hs_b = hs_b;
        for (int k = 0; k < 2 * FR * PDA + 4 * HT * PDA && fs_seen < 2; k++) begin
            advance();
            checks += 2;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL timing_a n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL timing_b n=%0d got=%h exp=%h", n, obs_b, exp_b);
            end
            if (p_hs_a && !hs_a) begin
                if (a_fall >= 0 && !d_line) begin
                    d_line = 1; checks++;
                    if (n - a_fall != HT * PDA) begin
                        failures++;
                        $display("FAIL line_period_a got=%0d exp=%0d", n - a_fall, HT * PDA);
                    end
                end
                a_fall = n;
            end
            if (!p_hs_a && hs_a && a_fall >= 0 && !d_hw) begin
                d_hw = 1; checks++;
                if (n - a_fall != HS * PDA) begin
                    failures++;
                    $display("FAIL hsync_width_a got=%0d exp=%0d", n - a_fall, HS * PDA);
                end
            end
            if (p_vs_a && !vs_a) a_vfall = n;
            if (!p_vs_a && vs_a && a_vfall >= 0 && !d_vw) begin
                d_vw = 1; checks++;
                if (n - a_vfall != VS * HT * PDA) begin
                    failures++;
                    $display("FAIL vsync_width_a got=%0d exp=%0d", n - a_vfall, VS * HT * PDA);
                end
            end
            if (!p_hs_b && hs_b) begin
                if (b_rise >= 0 && !d_bline) begin
                    d_bline = 1; checks++;
                    if (n - b_rise != HT * PDB) begin
                        failures++;
                        $display("FAIL line_period_b got=%0d exp=%0d", n - b_rise, HT * PDB);
                    end
                end
                b_rise = n;
            end
            if (p_hs_b && !hs_b && b_rise >= 0 && !d_bw) begin
                d_bw = 1; checks++;
                if (n - b_rise != HS * PDB) begin
                    failures++;
                    $display("FAIL hsync_width_b got=%0d exp=%0d", n - b_rise, HS * PDB);
                end
            end
            if (fs_a) begin
                if (fs_last >= 0) begin
                    checks++;
                    if (n - fs_last != FR * PDA) begin
                        failures++;
                        $display("FAIL frame_period_a got=%0d exp=%0d", n - fs_last, FR * PDA);
                    end
                end
                fs_last = n;
                fs_seen++;
            end
            p_hs_a = hs_a; p_vs_a = vs_a; p_hs_b = hs_b;
        end
        checks++;
        if (fs_seen != 2 || !d_line || !d_hw || !d_vw || !d_bline || !d_bw) begin
            failures++;
            $display("FAIL timing_events_seen got=%0d exp=2", fs_seen);
        end
    endtask

    // Change mode/switches mid-frame, then follow into the next frame.
    task automatic test_pattern_switch(input logic [1:0] m, input logic [2:0] s,
                                       input int end_py);
        int start_py;
        bit seen_fs, done;
        logic [2:0] bars [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        start_py = $urandom_range(6, 14);
        done = 0;
        for (int k = 0; k < 2 * FR * PDA && !done; k++) begin
            advance();
            checks++;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL switch_wait_a n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
            done = (int'(exp_a.py) == start_py);
        end
        mode = m;
        sw = s;
        seen_fs = 0;
        done = 0;
        for (int k = 0; k < 2 * FR * PDA && !done; k++) begin
            advance();
            checks += 2;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL switch_a m=%0d n=%0d got=%h exp=%h", m, n, obs_a, exp_a);
            end
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL switch_b m=%0d n=%0d got=%h exp=%h", m, n, obs_b, exp_b);
            end
            if (m == 2'd0 && sh_mode_b == 2'd0 && sh_sw_b == 3'b100 && exp_b.von) begin
                checks++;
                if (rgb_b !== 12'hF00) begin
                    failures++;
                    $display("FAIL red_12bit_b got=%h exp=f00", rgb_b);
                end
            end
            seen_fs = seen_fs | exp_a.fs;
            if (seen_fs) begin
                if (m == 2'd0) begin
                    checks++;
                    if (rgb_a !== (exp_a.von ? s : 3'b000)) begin
                        failures++;
                        $display("FAIL solid_a x=%0d y=%0d got=%b exp_sw=%b", exp_a.px,
                                 exp_a.py, rgb_a, s);
                    end
                end else if (m == 2'd1 && exp_a.py == 0) begin
                    if (exp_a.px < HA && exp_a.px % 6 == 0) begin
                        checks++;
                        if (rgb_a !== bars[exp_a.px / 6]) begin
                            failures++;
                            $display("FAIL bar_a x=%0d got=%b exp=%b", exp_a.px, rgb_a,
                                     bars[exp_a.px / 6]);
                        end
                    end else if (exp_a.px >= HA) begin
                        checks++;
                        if (rgb_a !== 3'b000) begin
                            failures++;
                            $display("FAIL bar_blank_a x=%0d got=%b exp=000", exp_a.px, rgb_a);
                        end
                    end
                end else if (m == 2'd2) begin
                    if (exp_a.px == 0 && exp_a.py == 0) begin
                        checks++;
                        if (rgb_a !== 3'b100) begin
                            failures++;
                            $display("FAIL chk_0_0 got=%b exp=100", rgb_a);
                        end
                    end
                    if (exp_a.px == 32 && exp_a.py == 0) begin
                        checks++;
                        if (rgb_a !== 3'b011) begin
                            failures++;
                            $display("FAIL chk_32_0 got=%b exp=011", rgb_a);
                        end
                    end
                    if (exp_a.px == 32 && exp_a.py == 32) begin
                        checks++;
                        if (rgb_a !== 3'b100) begin
                            failures++;
                            $display("FAIL chk_32_32 got=%b exp=100", rgb_a);
                        end
                    end
                end
                done = (int'(exp_a.py) == end_py);
            end
        end
        checks++;
        if (!seen_fs) begin
            failures++;
            $display("FAIL switch_no_frame got=0 exp=1");
        end
    endtask

    task automatic test_random_inputs();
        for (int k = 0; k < 3 * FR * PDA / 2; k++) begin
            advance();
            checks += 2;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL random_a n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL random_b n=%0d got=%h exp=%h", n, obs_b, exp_b);
            end
            if ($urandom_range(0, 299) == 0) begin
                mode = 2'($urandom_range(0, 3));
                sw = 3'($urandom_range(0, 7));
            end
        end
    endtask

    task automatic test_reset_mid();
        int first_a = -1, first_b = -1;
        int r = $urandom_range(50, 2000);
        for (int k = 0; k < r; k++) begin
            advance();
            checks++;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL pre_reset_a n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
        end
        #2 reset = 1'b0;
        #1;
        n = 0;
        sh_mode_a = 2'b00; sh_sw_a = 3'b000;
        sh_mode_b = 2'b00; sh_sw_b = 3'b000;
        exp_a = model(0, PDA, 1, 1'b0, 2'b00, 3'b000);
        exp_b = model(0, PDB, 4, 1'b1, 2'b00, 3'b000);
        checks += 2;
        if (obs_a !== exp_a) begin
            failures++;
            $display("FAIL mid_reset_async_a got=%h exp=%h", obs_a, exp_a);
        end
        if (obs_b !== exp_b) begin
            failures++;
            $display("FAIL mid_reset_async_b got=%h exp=%h", obs_b, exp_b);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) advance();
        reset = 1'b1;
        for (int k = 0; k < 4 * HT * PDA && (first_a < 0 || first_b < 0); k++) begin
            advance();
            checks += 2;
            if (obs_a !== exp_a) begin
                failures++;
                $display("FAIL post_reset_a n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
            if (obs_b !== exp_b) begin
                failures++;
                $display("FAIL post_reset_b n=%0d got=%h exp=%h", n, obs_b, exp_b);
            end
            if (first_a < 0 && hs_a === 1'b0) first_a = n;
            if (first_b < 0 && hs_b === 1'b1) first_b = n;
        end
        checks += 2;
        if (first_a != (HA + HFP) * PDA + 1) begin
            failures++;
            $display("FAIL first_hsync_a got=%0d exp=%0d", first_a, (HA + HFP) * PDA + 1);
        end
        if (first_b != (HA + HFP) * PDB + 1) begin
            failures++;
            $display("FAIL first_hsync_b got=%0d exp=%0d", first_b, (HA + HFP) * PDB + 1);
        end
    endtask

    initial begin
        test_reset();
        test_sync_timing();
        test_pattern_switch(2'd0, 3'b100, 4);
        test_pattern_switch(2'd0, 3'b010, 4);
        test_pattern_switch(2'd0, 3'b001, 4);
        test_pattern_switch(2'd1, 3'b001, 2);
        test_pattern_switch(2'd2, 3'b100, VA);
        test_random_inputs();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line, a multiple of 8.
REQ-002 Parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33: vertical equivalents, in lines.
REQ-004 Parameters H_POL, V_POL, default 0: active level of hsync and vsync.
REQ-005 Parameter PIX_DIV, default 2: clk cycles per pixel, at least 1.
REQ-006 Parameter RGB_W, default 1: bits per colour channel.
REQ-007 Parameter CHK_LOG2, default 5: checker square side is 2^CHK_LOG2 pixels.
REQ-008 clk  in  1  system clock; all logic is on the rising edge.
REQ-009 reset  in  1  asynchronous, active-low (0 = reset).
REQ-010 rgbswitches  in  3  colour select: bit2 red, bit1 green, bit0 blue.
REQ-011 mode  in  2  pattern select.
REQ-012 rgbtext  out  3*RGB_W  pixel colour as {R,G,B}.
REQ-013 hsync, vsync  out  1  sync outputs.
REQ-014 video_on  out  1  high while in the active region.
REQ-015 pixel_x  out  log2(H_TOTAL), pixel_y  out  log2(V_TOTAL)  current coordinates.
REQ-016 frame_start  out  1  one-clk pulse at the start of each frame.

Function
REQ-017 Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
REQ-018 Pixel-tick divider counts 0..PIX_DIV-1 and wraps; tick is asserted when the count equals PIX_DIV-1; when PIX_DIV=1, tick is asserted every clk.
REQ-019 h_cnt advances on each tick and wraps from H_TOTAL-1 to 0.
REQ-020 v_cnt advances on each tick on which h_cnt wraps, and wraps from V_TOTAL-1 to 0.
REQ-021 Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-022 hsync: equals H_POL for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise ~H_POL.
REQ-023 vsync: equals V_POL for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; otherwise ~V_POL.
REQ-024 Output registers: hsync, vsync, video_on, pixel_x, pixel_y and rgbtext are registered, decoded from the counter values, with 1 clk latency, and stay mutually aligned.
REQ-025 Shadow registers: mode and rgbswitches load into shadow registers only on the tick where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
REQ-026 Shadow registers: pattern generation uses only the shadow values, so any change takes effect at the next frame boundary and never mid-frame.
REQ-027 frame_start is high for exactly one clk, aligned with the outputs for (0,0).
REQ-028 Full-scale channel value is all ones in RGB_W bits.
REQ-029 Channel colour c[2:0] maps to rgbtext = {RGB_W{c2}, RGB_W{c1}, RGB_W{c0}}.
REQ-030 Mode 0 (solid): c = shadow rgbswitches.
REQ-031 Mode 1 (colour bars): bar b = pixel_x / (H_ACTIVE/8), giving 0..7; c = 7-b, so bar 0 is white and bar 7 is black.
REQ-032 Mode 2 (checker): when pixel_x[CHK_LOG2] XOR pixel_y[CHK_LOG2] is 0, c = shadow rgbswitches; otherwise c = its bitwise inverse.
REQ-033 Mode 3: c = 0 (black).
REQ-034 rgbtext is 0 whenever video_on is low, in every mode.
REQ-035 Inputs changing on the load tick are captured; inputs changing on any other tick do not affect the current frame.

Reset
REQ-036 While reset=0, all of the following hold immediately and asynchronously: divider, h_cnt and v_cnt are 0; shadow mode=0 and shadow colour=0; hsync=~H_POL and vsync=~V_POL; video_on, rgbtext, pixel_x, pixel_y and frame_start are 0.
REQ-037 Asserting reset mid-line or mid-frame abandons the frame.
REQ-038 After reset release, counting restarts at (0,0).
REQ-039 frame_start is not pulsed for the first frame after reset.
REQ-040 The first tick after release occurs PIX_DIV clk edges after release.

Verification
REQ-041 Sync timing (default parameters, reset released):
- hsync goes low at h_cnt 656 for 96 ticks = 192 clk.
- The line period is 1600 clk.
- vsync is low for lines 490-491 = 3200 clk.
- The frame period is 840000 clk.
REQ-042 Frame-boundary switch change:
- Stimulus: mode=0; rgbswitches changed from 3'b000 to 3'b100 mid-frame.
- Response: rgbtext stays 0 until the next frame_start, then is 3'b100 inside the active region and 0 in blanking.
- Repeat with 3'b010 and 3'b001 for green and blue.
REQ-043 Colour bars: mode=1 gives pixel_x 0-79 = 3'b111, 80-159 = 3'b110, ..., 560-639 = 3'b000, with rgbtext=0 for pixel_x >= 640.
REQ-044 Checker: mode=2 with rgbswitches=3'b100 gives (0,0)=3'b100, (32,0)=3'b011 and (32,32)=3'b100.
REQ-045 Reset mid-operation: reset=0 at an arbitrary cycle forces the outputs to their REQ-036 values within the same cycle, without waiting for a clk edge; after release, the first hsync assertion comes 656*PIX_DIV+1 clk later.
REQ-046 Parameter sweep with PIX_DIV=1, RGB_W=4 and H/V_POL=1:
- Period checks scale to 800 clk per line.
- Sync pulses are active-high.
- Red is 12'hF00.
